// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges pipeline results with a FIFO of long-latency (mul/div) results.
// Optional starvation guard is compiled in when WB_STARVE_GUARD_EN is defined.
module wb_arbiter #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              pipe_valid,
  input  logic [4:0]        pipe_addr,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              lu_valid,
  input  logic [4:0]        lu_addr,
  input  logic [DATA_W-1:0] lu_data,
  output logic              lu_ready,
  output logic              pipe_stall,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [4:0]        mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic              fifo_nonempty;
  logic              push;
  logic              pop;
  logic              stall;
  logic              sel_valid;
  logic [4:0]        sel_addr;
  logic [DATA_W-1:0] sel_data;

  assign fifo_nonempty = (count_q != '0);

  // Readiness comes from registered occupancy only; gating with reset keeps it low while held.
  assign lu_ready = sys_rst & (count_q < DEPTH_C);
  assign push     = lu_valid & lu_ready & (lu_addr != '0);

`ifdef WB_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

  logic [SW-1:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (!fifo_nonempty || pop) begin
      starve_d = '0;
    end else if (starve_q != STARVE_C) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign stall = (starve_q == STARVE_C);
`else
  assign stall = 1'b0;
`endif

  assign pipe_stall = stall;

  // Priority: forced drain, then pipeline, then opportunistic drain.
  always_comb begin
    pop       = 1'b0;
    sel_valid = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    if (stall) begin
      if (fifo_nonempty) begin
        pop       = 1'b1;
        sel_valid = 1'b1;
        sel_addr  = mem_addr[rd_ptr_q];
        sel_data  = mem_data[rd_ptr_q];
      end
    end else if (pipe_valid) begin
      sel_valid = 1'b1;
      sel_addr  = pipe_addr;
      sel_data  = pipe_data;
    end else if (fifo_nonempty) begin
      pop       = 1'b1;
      sel_valid = 1'b1;
      sel_addr  = mem_addr[rd_ptr_q];
      sel_data  = mem_data[rd_ptr_q];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Writes to r0 are dropped and leave address/data unchanged.
  always_comb begin
    rf_we_d    = sel_valid & (sel_addr != '0);
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (rf_we_d) begin
      rf_waddr_d = sel_addr;
      rf_wdata_d = sel_data;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem_addr[wr_ptr_q] <= lu_addr;
      mem_data[wr_ptr_q] <= lu_data;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios then random traffic against a queue model.
module tb_wb_arbiter;

  localparam int DATA_W     = 64;
  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;
`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              sys_clk;
  logic              sys_rst;
  logic              pipe_valid;
  logic [4:0]        pipe_addr;
  logic [DATA_W-1:0] pipe_data;
  logic              lu_valid;
  logic [4:0]        lu_addr;
  logic [DATA_W-1:0] lu_data;
  logic              lu_ready;
  logic              pipe_stall;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [4:0]        a;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t              q[$];
  int                m_starve = 0;
  logic              exp_we   = 1'b0;
  logic [4:0]        exp_wa   = '0;
  logic [DATA_W-1:0] exp_wd   = '0;

  wb_arbiter #(
    .DATA_W(DATA_W),
    .DEPTH(DEPTH),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .pipe_valid(pipe_valid),
    .pipe_addr(pipe_addr),
    .pipe_data(pipe_data),
    .lu_valid(lu_valid),
    .lu_addr(lu_addr),
    .lu_data(lu_data),
    .lu_ready(lu_ready),
    .pipe_stall(pipe_stall),
    .rf_we(rf_we),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #1000000;
    n_fail++;
    $error("FAIL timeout: test did not finish within the wait limit");
    $finish;
  end

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_starve = 0;
    exp_we   = 1'b0;
    exp_wa   = '0;
    exp_wd   = '0;
  endtask

  // One clock cycle: drive inputs, check handshake outputs, advance model, check registered write.
  task automatic step(input logic pv, input logic [4:0] pa, input logic [DATA_W-1:0] pd,
                      input logic lv, input logic [4:0] la, input logic [DATA_W-1:0] ld);
    bit                m_ready;
    bit                m_stall;
    int                n0;
    bit                popped;
    bit                wv;
    logic [4:0]        wa;
    logic [DATA_W-1:0] wd;
    ent_t              e;
    pipe_valid = pv;
    pipe_addr  = pa;
    pipe_data  = pd;
    lu_valid   = lv;
    lu_addr    = la;
    lu_data    = ld;
    #1;
    m_ready = (q.size() < DEPTH);
    m_stall = GUARD && (m_starve == STARVE_MAX);
    chk("lu_ready", lu_ready, m_ready);
    chk("pipe_stall", pipe_stall, m_stall);
    n0     = q.size();
    popped = 1'b0;
    wv     = 1'b0;
    wa     = '0;
    wd     = '0;
    if (m_stall) begin
      if (n0 > 0) begin
        e = q.pop_front(); popped = 1'b1; wv = 1'b1; wa = e.a; wd = e.d;
      end
    end else if (pv) begin
      wv = 1'b1; wa = pa; wd = pd;
    end else if (n0 > 0) begin
      e = q.pop_front(); popped = 1'b1; wv = 1'b1; wa = e.a; wd = e.d;
    end
    if (lv && m_ready && la != 5'd0) q.push_back('{a: la, d: ld});
    if (n0 == 0 || popped) m_starve = 0;
    else if (m_starve < STARVE_MAX) m_starve = m_starve + 1;
    if (wv && wa != 5'd0) begin
      exp_we = 1'b1; exp_wa = wa; exp_wd = wd;
    end else begin
      exp_we = 1'b0;
    end
    @(posedge sys_clk);
    #1;
    chk("rf_we", rf_we, exp_we);
    chk("rf_waddr", rf_waddr, exp_wa);
    chk("rf_wdata", rf_wdata, exp_wd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
  endtask

  initial begin
    logic [4:0]        ra;
    logic [DATA_W-1:0] rd;
    sys_rst    = 1'b0;
    pipe_valid = 1'b0;
    pipe_addr  = '0;
    pipe_data  = '0;
    lu_valid   = 1'b0;
    lu_addr    = '0;
    lu_data    = '0;
    #1;
    chk("rst_we", rf_we, 1'b0);
    chk("rst_waddr", rf_waddr, 5'd0);
    chk("rst_wdata", rf_wdata, 64'd0);
    chk("rst_stall", pipe_stall, 1'b0);
    chk("rst_ready", lu_ready, 1'b0);
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    model_reset();

    // first cycle after release, then pipeline write with 1-cycle latency
    step(1'b1, 5'd5, 64'hAA, 1'b0, 5'd0, '0);
    chk("pipe_we", rf_we, 1'b1);
    chk("pipe_waddr", rf_waddr, 5'd5);
    chk("pipe_wdata", rf_wdata, 64'hAA);
    idle(1);
    chk("idle_hold_waddr", rf_waddr, 5'd5);

    // long-latency result with idle pipe: visible two edges later
    step(1'b0, 5'd0, '0, 1'b1, 5'd7, 64'h55);
    chk("lu_not_bypassed", rf_we, 1'b0);
    idle(1);
    chk("lu_we", rf_we, 1'b1);
    chk("lu_waddr", rf_waddr, 5'd7);
    chk("lu_wdata", rf_wdata, 64'h55);
    idle(2);

    // three lu results back-to-back under continuous pipe traffic
    step(1'b1, 5'd1, 64'h101, 1'b1, 5'd11, 64'hB1);
    step(1'b1, 5'd2, 64'h102, 1'b1, 5'd12, 64'hB2);
    step(1'b1, 5'd3, 64'h103, 1'b1, 5'd13, 64'hB3);
    step(1'b1, 5'd4, 64'h104, 1'b0, 5'd0, '0);
    idle(4);

    // one queued entry with pipe always busy (forced drain when guarded)
    step(1'b1, 5'd20, 64'h200, 1'b1, 5'd9, 64'h99);
    for (int i = 0; i < 7; i++) step(1'b1, 5'(21 + i), 64'(i + 'h300), 1'b0, 5'd0, '0);
    idle(3);

    // address-0 writes from both sources
    step(1'b1, 5'd0, 64'hFF, 1'b1, 5'd0, 64'h33);
    chk("r0_pipe_we", rf_we, 1'b0);
    idle(1);
    chk("r0_lu_we", rf_we, 1'b0);
    chk("r0_ready", lu_ready, 1'b1);

    // fill FIFO, then reset mid-operation
    step(1'b1, 5'd1, 64'h1, 1'b1, 5'd14, 64'hE1);
    step(1'b1, 5'd2, 64'h2, 1'b1, 5'd15, 64'hE2);
    chk("full_ready", lu_ready, 1'b0);
    sys_rst = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_we", rf_we, 1'b0);
    chk("mid_rst_waddr", rf_waddr, 5'd0);
    chk("mid_rst_wdata", rf_wdata, 64'd0);
    chk("mid_rst_stall", pipe_stall, 1'b0);
    chk("mid_rst_ready", lu_ready, 1'b0);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    idle(4);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      ra = 5'($urandom_range(0, 31));
      rd = {$urandom(), $urandom()};
      step(1'($urandom_range(0, 99) < 60), 5'($urandom_range(0, 31)), {$urandom(), $urandom()},
           1'($urandom_range(0, 99) < 45), ra, rd);
    end
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
